// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Package  : i2c_cfg_pkg
// Brief    : Shared widths, FSM state encoding and a saturating-increment
//            helper for the I2C configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_cfg_pkg;

    localparam int I2C_WORD_W  = 24;
    localparam int CFG_ENTRY_W = 16;
    localparam int IDX_W       = 6;

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_GO    = 3'd2,
        S_CHECK = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } cfg_state_t;

    // Increment an 8-bit count, holding at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage : i2c_cfg_pkg
`default_nettype wire

// File: rtl/i2c_cfg_rom.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : i2c_cfg_rom
// Brief    : Combinational configuration table, index -> {sub_addr, data}.
//            Indices at or beyond NUM_ENTRIES read as 16'h0000.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_rom
    import i2c_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 10
) (
    input  logic [IDX_W-1:0]       idx,
    output logic [CFG_ENTRY_W-1:0] entry
);

    // Table lookup; anything past the configured length is forced to zero
    always_comb begin
        entry = 16'h0000;
        if (int'(idx) < NUM_ENTRIES) begin
            case (idx)
                6'd0:    entry = 16'h1E00;
                6'd1:    entry = 16'h0C00;
                6'd2:    entry = 16'h0E42;
                6'd3:    entry = 16'h1000;
                6'd4:    entry = 16'h0017;
                6'd5:    entry = 16'h0217;
                6'd6:    entry = 16'h0479;
                6'd7:    entry = 16'h0679;
                6'd8:    entry = 16'h0812;
                6'd9:    entry = 16'h1201;
                default: entry = 16'h0000;
            endcase
        end
    end

endmodule : i2c_cfg_rom
`default_nettype wire

// File: rtl/i2c_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : i2c_cfg_sequencer
// Brief    : Walks the configuration table after power-up, issuing one
//            24-bit write to the I2C engine per entry via the GO/END/ACK
//            handshake, and reports DONE or ERROR with a failed-entry count.
// Config   : I2C_CFG_RETRY_EN - when defined, a NACKed entry is re-sent up
//            to MAX_RETRY times before it is counted as failed.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int          NUM_ENTRIES = 10,
    parameter logic [7:0]  SLAVE_ADDR  = 8'h34,
    parameter logic [15:0] POWERUP_DLY = 16'd2000,
    parameter int          GAP_CYCLES  = 4,
    parameter int          MAX_RETRY   = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  START,
    output logic [I2C_WORD_W-1:0] I2C_DATA,
    output logic                  GO,
    output logic                  W_R,
    input  logic                  END,
    input  logic                  ACK,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [7:0]            ERR_COUNT,
    output logic [IDX_W-1:0]      INDEX
);

    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    // Reject parameter sets the handshake cannot honour
    generate
        if (NUM_ENTRIES < 1 || NUM_ENTRIES > 64 || GAP_CYCLES < 2 ||
            MAX_RETRY < 0 || MAX_RETRY > 255) begin : g_bad_params
            $error("i2c_cfg_sequencer: parameter out of range");
        end
    endgenerate

    cfg_state_t              state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    armed_q, armed_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic [7:0]              err_q, err_d;
    logic [I2C_WORD_W-1:0]   data_q, data_d;
    logic                    go_q, go_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
`ifdef I2C_CFG_RETRY_EN
    logic [7:0]              retry_q, retry_d;
`endif

    logic [CFG_ENTRY_W-1:0]  rom_entry;

    i2c_cfg_rom #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_rom (
        .idx   (index_q),
        .entry (rom_entry)
    );

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        index_d = index_q;
        err_d   = err_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef I2C_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_PWRUP: begin
                // 17-bit compare keeps POWERUP_DLY of 0 or 16'hFFFF well defined
                if (({1'b0, cnt_q} + 17'd1) >= {1'b0, POWERUP_DLY}) begin
                    cnt_d   = 16'd0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_LOAD: begin
                data_d = {SLAVE_ADDR, rom_entry};
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    armed_d = 1'b0;
                    state_d = S_GO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_GO: begin
                // An END still high from the previous transfer must be seen
                // low once before a rising END counts as completion
                if (!armed_q) begin
                    if (!END) begin
                        armed_d = 1'b1;
                    end
                end else if (END) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!ACK) begin
`ifdef I2C_CFG_RETRY_EN
                    retry_d = 8'd0;
`endif
                    state_d = S_NEXT;
                end else begin
`ifdef I2C_CFG_RETRY_EN
                    if (retry_q < 8'(MAX_RETRY)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_LOAD;
                    end else begin
                        retry_d = 8'd0;
                        err_d   = sat_inc8(err_q);
                        state_d = S_NEXT;
                    end
`else
                    err_d   = sat_inc8(err_q);
                    state_d = S_NEXT;
`endif
                end
            end
            S_NEXT: begin
                if (index_q == IDX_LAST) begin
                    busy_d = 1'b0;
                    if (err_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end else begin
                    index_d = index_q + 6'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE, S_ERROR: begin
                if (START) begin
                    index_d = '0;
                    err_d   = 8'd0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = 16'd0;
`ifdef I2C_CFG_RETRY_EN
                    retry_d = 8'd0;
`endif
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase
        // GO is a registered level that is high exactly while in S_GO
        go_d = (state_d == S_GO);
    end

    // State and output registers; async reset drops GO immediately
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_PWRUP;
            cnt_q   <= 16'd0;
            armed_q <= 1'b0;
            index_q <= '0;
            err_q   <= 8'd0;
            data_q  <= '0;
            go_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
            retry_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            index_q <= index_d;
            err_q   <= err_d;
            data_q  <= data_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef I2C_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign I2C_DATA  = data_q;
    assign GO        = go_q;
    assign W_R       = 1'b0;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;
    assign ERR_COUNT = err_q;
    assign INDEX     = index_q;

endmodule : i2c_cfg_sequencer
`default_nettype wire

// File: tb/tb_i2c_cfg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_i2c_cfg_sequencer
// Brief    : Self-checking bench with a behavioural I2C engine responder and
//            a transfer-log reference model for the configuration sequencer.
//            Expectations follow I2C_CFG_RETRY_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_cfg_sequencer;

    localparam int          N    = 10;
    localparam logic [15:0] PWR  = 16'd10;
    localparam int          GAP  = 4;
    localparam int          MAXR = 3;
`ifdef I2C_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        END   = 1'b1;
    logic        ACK   = 1'b0;
    logic [23:0] I2C_DATA;
    logic        GO, W_R, BUSY, DONE, ERROR;
    logic [7:0]  ERR_COUNT;
    logic [5:0]  INDEX;

    i2c_cfg_sequencer #(
        .NUM_ENTRIES (N),
        .SLAVE_ADDR  (8'h34),
        .POWERUP_DLY (PWR),
        .GAP_CYCLES  (GAP),
        .MAX_RETRY   (MAXR)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .I2C_DATA  (I2C_DATA),
        .GO        (GO),
        .W_R       (W_R),
        .END       (END),
        .ACK       (ACK),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERROR     (ERROR),
        .ERR_COUNT (ERR_COUNT),
        .INDEX     (INDEX)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int errors = 0;

    // Configuration table contents the design is expected to send
    logic [15:0] tbl [0:9] = '{16'h1E00, 16'h0C00, 16'h0E42, 16'h1000, 16'h0017,
                               16'h0217, 16'h0479, 16'h0679, 16'h0812, 16'h1201};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- engine responder and transfer log ----------------
    int          mode = 0;        // 0 ack all, 1 nack entry once, 2 nack entry always, 3 random
    int          nack_entry = 0;
    int          eng_st = 0;      // 0 idle, 1 transferring, 2 finished, waiting for GO low
    int          eng_cnt, stale_n, len_n;
    logic [23:0] cur_data;
    logic [23:0] tx_data [$];
    int          tx_idx  [$];
    bit          tx_nack [$];
    int          seen    [0:63];

    function automatic bit decide_nack(input int idx);
        case (mode)
            1:       return (idx == nack_entry) && (seen[idx] == 0);
            2:       return (idx == nack_entry);
            3:       return ($urandom_range(0, 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge CLOCK) begin
        if (!GO) begin
            eng_st = 0;
        end else begin
            if (eng_st == 0) begin
                eng_st   = 1;
                eng_cnt  = 0;
                stale_n  = int'($urandom_range(0, 3));
                len_n    = int'($urandom_range(2, 8));
                cur_data = I2C_DATA;
                tx_data.push_back(I2C_DATA);
                tx_idx.push_back(int'(INDEX));
            end
            if (eng_st == 1) begin
                if (eng_cnt >= stale_n + len_n) begin
                    ACK = decide_nack(int'(INDEX));
                    END = 1'b1;
                    tx_nack.push_back(ACK);
                    seen[INDEX] = seen[INDEX] + 1;
                    chk("data_stable", {8'h0, I2C_DATA}, {8'h0, cur_data});
                    eng_st = 2;
                end else if (eng_cnt >= stale_n) begin
                    END = 1'b0;
                end
                eng_cnt++;
            end
        end
    end

    // Per-cycle invariants of the status outputs
    always @(negedge CLOCK) begin
        if (RESET) begin
            chk("w_r_zero", {31'd0, W_R}, 32'd0);
            chk("busy_vs_flags", {31'd0, BUSY}, {31'd0, !(DONE | ERROR)});
            chk("done_error_excl", {31'd0, DONE & ERROR}, 32'd0);
            if (GO) chk("go_implies_busy", {31'd0, BUSY}, 32'd1);
        end
    end

    task automatic clear_log();
        tx_data.delete();
        tx_idx.delete();
        tx_nack.delete();
        for (int i = 0; i < 64; i++) seen[i] = 0;
    endtask

    function automatic int count_sent(input int idx);
        int c = 0;
        foreach (tx_idx[i]) if (tx_idx[i] == idx) c++;
        return c;
    endfunction

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge CLOCK);
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic measure_go(output int k);
        k = 0;
        while (k < 200) begin
            @(negedge CLOCK);
            k++;
            if (GO) break;
        end
    endtask

    // Reference model: replay the logged ACK outcomes through the table rules
    task automatic walk(input string name);
        int idx = 0;
        int att = 0;
        int err = 0;
        int n   = tx_nack.size();
        chk({name, "_log_sizes"}, tx_data.size(), n);
        for (int i = 0; i < n; i++) begin
            if (idx >= N) begin
                chk({name, "_extra_transfer"}, i, n);
                break;
            end
            chk({name, "_word"}, {8'h0, tx_data[i]}, {8'h0, 8'h34, tbl[idx]});
            chk({name, "_index"}, tx_idx[i], idx);
            if (!tx_nack[i]) begin
                att = 0;
                idx++;
            end else if (RETRY && att < MAXR) begin
                att++;
            end else begin
                err = (err == 255) ? 255 : err + 1;
                att = 0;
                idx++;
            end
        end
        chk({name, "_entries_done"}, idx, N);
        chk({name, "_done"}, {31'd0, DONE}, (err == 0) ? 32'd1 : 32'd0);
        chk({name, "_error"}, {31'd0, ERROR}, (err != 0) ? 32'd1 : 32'd0);
        chk({name, "_err_count"}, {24'd0, ERR_COUNT}, err);
        chk({name, "_busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit ok;
        clear_log();
        #2 RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        chk("rst_go", {31'd0, GO}, 32'd0);
        chk("rst_data", {8'h0, I2C_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd1);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_error", {31'd0, ERROR}, 32'd0);
        chk("rst_err_count", {24'd0, ERR_COUNT}, 32'd0);
        chk("rst_index", {26'd0, INDEX}, 32'd0);

        // Pass 1: everything acknowledged, START while busy must be ignored
        RESET = 1'b1;
        measure_go(k);
        chk("pwrup_go_rise", k, int'(PWR) + GAP);
        repeat (20) @(negedge CLOCK);
        START = 1'b1;
        repeat (3) @(negedge CLOCK);
        START = 1'b0;
        wait_idle("pass1");
        walk("pass1");
        chk("pass1_count", tx_data.size(), N);
        chk("pass1_done_lit", {31'd0, DONE}, 32'd1);

        // Pass 2: entry 3 NACKed once; restart has no power-up delay
        clear_log();
        mode = 1;
        nack_entry = 3;
        pulse_start();
        chk("restart_busy", {31'd0, BUSY}, 32'd1);
        chk("restart_index", {26'd0, INDEX}, 32'd0);
        measure_go(k);
        chk("restart_go_rise", k, GAP);
        wait_idle("pass2");
        walk("pass2");
        chk("pass2_entry3_sent", count_sent(3), RETRY ? 2 : 1);
        chk("pass2_done_lit", {31'd0, DONE}, RETRY ? 32'd1 : 32'd0);
        chk("pass2_errcnt_lit", {24'd0, ERR_COUNT}, RETRY ? 32'd0 : 32'd1);

        // Pass 3: entry 5 NACKed every time
        clear_log();
        mode = 2;
        nack_entry = 5;
        pulse_start();
        wait_idle("pass3");
        walk("pass3");
        chk("pass3_entry5_sent", count_sent(5), RETRY ? 4 : 1);
        chk("pass3_entry9_sent", count_sent(9), 1);
        chk("pass3_error_lit", {31'd0, ERROR}, 32'd1);
        chk("pass3_errcnt_lit", {24'd0, ERR_COUNT}, 32'd1);

        // Passes 4..6: random NACKs, restarted from S_ERROR / S_DONE
        mode = 3;
        for (int p = 0; p < 3; p++) begin
            clear_log();
            pulse_start();
            chk("rand_restart_errcnt", {24'd0, ERR_COUNT}, 32'd0);
            chk("rand_restart_flags", {30'd0, DONE, ERROR}, 32'd0);
            wait_idle("rand");
            walk("rand");
        end

        // Pass 7: reset in the middle of entry 2
        mode = 0;
        clear_log();
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLOCK);
            if (GO && INDEX == 6'd2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_entry2", {31'd0, ok}, 32'd1);
        repeat (2) @(negedge CLOCK);
        #2 RESET = 1'b0;
        #1;
        chk("midreset_go", {31'd0, GO}, 32'd0);
        chk("midreset_index", {26'd0, INDEX}, 32'd0);
        chk("midreset_busy", {31'd0, BUSY}, 32'd1);
        @(negedge CLOCK);
        clear_log();
        RESET = 1'b1;
        measure_go(k);
        chk("midreset_go_rise", k, int'(PWR) + GAP);
        wait_idle("pass7");
        walk("pass7");
        chk("pass7_count", tx_data.size(), N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_i2c_cfg_sequencer
`default_nettype wire
